// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer: FSM states, mode codes, presets.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // {c2,c1} switch codes
    localparam logic [1:0] MODE_5S  = 2'b00;
    localparam logic [1:0] MODE_30S = 2'b01;
    localparam logic [1:0] MODE_1M  = 2'b10;
    localparam logic [1:0] MODE_2M  = 2'b11;

    // Preset minutes/seconds per mode
    localparam logic [1:0] PRESET_MIN_5S  = 2'd0;
    localparam logic [5:0] PRESET_SEC_5S  = 6'd5;
    localparam logic [1:0] PRESET_MIN_30S = 2'd0;
    localparam logic [5:0] PRESET_SEC_30S = 6'd30;
    localparam logic [1:0] PRESET_MIN_1M  = 2'd1;
    localparam logic [5:0] PRESET_SEC_1M  = 6'd0;
    localparam logic [1:0] PRESET_MIN_2M  = 2'd2;
    localparam logic [5:0] PRESET_SEC_2M  = 6'd0;

    localparam logic [5:0] SEC_MAX = 6'd59;

    // Preset for a mode code, packed as {minutes, seconds}
    function automatic logic [7:0] preset_of(input logic [1:0] code);
        case (code)
            MODE_5S:  preset_of = {PRESET_MIN_5S,  PRESET_SEC_5S};
            MODE_30S: preset_of = {PRESET_MIN_30S, PRESET_SEC_30S};
            MODE_1M:  preset_of = {PRESET_MIN_1M,  PRESET_SEC_1M};
            default:  preset_of = {PRESET_MIN_2M,  PRESET_SEC_2M};
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// 1 s tick generator: counts 0..CLK_HZ-1 while run, holds when idle, zeroes on clr.
// Latency: tick is combinational on the last count of each period.
// Backpressure: none; run/clr are level controls from the FSM.
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int              CW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0]   TOP = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == TOP);

    // Period counter: wraps on tick, holds while paused, zeroed outside a count
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_core.sv
// Countdown timer (5 s / 30 s / 1 min / 2 min) with start/pause/resume and clear; optional
// buzzer via COUNTDOWN_ALARM_EN. Latency: value, state and done update on the tick edge.
// Backpressure: none; start/clear are single-cycle pulses acted on the cycle they arrive.
module countdown_core
    import countdown_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       start,
    input  logic       clear,
    output logic [1:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       expired,
    output logic       done,
    output logic       alarm
);

    state_t     state, state_nxt;
    logic [1:0] min_nxt, dec_min;
    logic [5:0] sec_nxt, dec_sec;
    logic [7:0] preset;
    logic       done_nxt;
    logic       tick;
    logic       presc_run, presc_clr;

    assign presc_run = (state == ST_RUN);
    assign presc_clr = (state == ST_IDLE) || (state == ST_DONE);

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_tick_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (presc_run),
        .clr  (presc_clr),
        .tick (tick)
    );

    assign running = (state == ST_RUN);
    assign expired = (state == ST_DONE);

    // Value after one decrement, borrowing a minute when seconds are zero
    always_comb begin
        preset  = preset_of(mode);
        dec_min = minutes;
        dec_sec = seconds;
        if (seconds != 6'd0) begin
            dec_sec = seconds - 6'd1;
        end else if (minutes != 2'd0) begin
            dec_min = minutes - 2'd1;
            dec_sec = SEC_MAX;
        end
    end

    // Next state, next displayed value and done pulse
    always_comb begin
        state_nxt = state;
        min_nxt   = minutes;
        sec_nxt   = seconds;
        done_nxt  = 1'b0;
        if (clear) begin
            // clear beats start; reload immediately so the display never shows stale progress
            state_nxt          = ST_IDLE;
            {min_nxt, sec_nxt} = preset;
        end else begin
            case (state)
                ST_IDLE: begin
                    {min_nxt, sec_nxt} = preset;
                    if (start) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (tick) begin
                        min_nxt = dec_min;
                        sec_nxt = dec_sec;
                        if (dec_min == 2'd0 && dec_sec == 6'd0) begin
                            // final tick: a coincident start is dropped
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end else if (start) begin
                            state_nxt = ST_PAUSE;
                        end
                    end else if (start) begin
                        state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start) state_nxt = ST_RUN;
                end
                ST_DONE: begin
                    if (start) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, value and done registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            minutes <= PRESET_MIN_5S;
            seconds <= PRESET_SEC_5S;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            minutes <= min_nxt;
            seconds <= sec_nxt;
            done    <= done_nxt;
        end
    end

`ifdef COUNTDOWN_ALARM_EN
    localparam int            AW      = $clog2(3 * CLK_HZ + 1);
    localparam logic [AW-1:0] ALM_LEN = AW'(3 * CLK_HZ);

    logic [AW-1:0] alm_cnt;

    // Buzzer: on for three tick periods from DONE entry, off as soon as DONE is left
    always_ff @(posedge clk) begin
        if (rst || state_nxt != ST_DONE) begin
            alarm   <= 1'b0;
            alm_cnt <= '0;
        end else if (state != ST_DONE) begin
            alarm   <= 1'b1;
            alm_cnt <= AW'(1);
        end else if (alm_cnt < ALM_LEN) begin
            alarm   <= 1'b1;
            alm_cnt <= alm_cnt + 1'b1;
        end else begin
            alarm   <= 1'b0;
        end
    end
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_core.sv
// Bench for countdown_core with CLK_HZ=4: directed scenarios plus random pulses,
// every cycle compared against a remaining-seconds reference model.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_countdown_core;

    localparam int CLK = 4;
`ifdef COUNTDOWN_ALARM_EN
    localparam int ALARM_CYC = 3 * CLK;
`else
    localparam int ALARM_CYC = 0;
`endif

    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_PAUSE = 2;
    localparam int PH_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst, start, clear;
    logic [1:0] mode;
    logic [1:0] minutes;
    logic [5:0] seconds;
    logic       running, expired, done, alarm;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: remaining time in plain seconds, cumulative RUN cycles
    int  m_phase = PH_IDLE;
    int  m_rem   = 5;
    int  m_runc  = 0;
    int  m_age   = 0;
    bit  m_done  = 1'b0;

    countdown_core #(.CLK_HZ(CLK)) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .start   (start),
        .clear   (clear),
        .minutes (minutes),
        .seconds (seconds),
        .running (running),
        .expired (expired),
        .done    (done),
        .alarm   (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int preset_s(input logic [1:0] md);
        case (md)
            2'd0:    return 5;
            2'd1:    return 30;
            2'd2:    return 60;
            default: return 120;
        endcase
    endfunction

    task automatic model_step(input bit r, input logic [1:0] md, input bit st, input bit cl);
        m_done = 1'b0;
        if (r) begin
            m_phase = PH_IDLE; m_rem = 5; m_runc = 0; m_age = 0;
        end else if (cl) begin
            m_phase = PH_IDLE; m_rem = preset_s(md); m_runc = 0;
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    m_rem = preset_s(md);
                    if (st) begin m_phase = PH_RUN; m_runc = 0; end
                end
                PH_RUN: begin
                    m_runc++;
                    if (m_runc % CLK == 0 && m_rem > 0) begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_phase = PH_DONE; m_done = 1'b1; m_age = 0; m_runc = 0;
                        end
                    end
                    if (m_phase == PH_RUN && st) m_phase = PH_PAUSE;
                end
                PH_PAUSE: if (st) m_phase = PH_RUN;
                default: begin
                    m_age++;
                    if (st) m_phase = PH_IDLE;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check("minutes", int'(minutes), m_rem / 60);
        check("seconds", int'(seconds), m_rem % 60);
        check("running", int'(running), int'(m_phase == PH_RUN));
        check("expired", int'(expired), int'(m_phase == PH_DONE));
        check("done",    int'(done),    int'(m_done));
        check("alarm",   int'(alarm),   int'(m_phase == PH_DONE && m_age < ALARM_CYC));
    endtask

    // one clock: drive at the falling edge, model at the rising edge, compare just after
    task automatic step(input bit r, input logic [1:0] md, input bit st, input bit cl);
        rst = r; mode = md; start = st; clear = cl;
        @(posedge clk);
        model_step(r, md, st, cl);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    initial begin
        int idx;
        int cnt;
        bit seen;
        logic [1:0] md;

        rst = 1'b1; mode = 2'd3; start = 1'b0; clear = 1'b0;
        @(negedge clk);

        // reset values, then the first IDLE cycle loads the mode preset
        step(1, 2'd3, 0, 0);
        check("rst_min", int'(minutes), 0);
        check("rst_sec", int'(seconds), 5);
        step(0, 2'd3, 0, 0);
        check("idle_2m_min", int'(minutes), 2);
        check("idle_2m_sec", int'(seconds), 0);

        // 5 s run: done visible after the 20th step following start
        step(0, 2'd0, 0, 0);
        step(0, 2'd0, 1, 0);
        idx = 0; seen = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            step(0, 2'd0, 0, 0);
            if (done) begin seen = 1; idx = i; end
        end
        check("done_at_step", idx, 20);
        check("done_expired", int'(expired), 1);
        // alarm length while sitting in DONE (entry cycle already observed)
        cnt = int'(alarm);
        for (int i = 0; i < 19; i++) begin
            step(0, 2'd0, 0, 0);
            cnt += int'(alarm);
        end
        check("alarm_cycles", cnt, ALARM_CYC);
        step(0, 2'd0, 1, 0);
        check("done_start_idle", int'(expired), 0);

        // 1:00 -> 0:59 on the first tick
        step(0, 2'd2, 0, 0);
        step(0, 2'd2, 1, 0);
        for (int i = 0; i < CLK; i++) step(0, 2'd2, 0, 0);
        check("borrow_min", int'(minutes), 0);
        check("borrow_sec", int'(seconds), 59);
        step(0, 2'd2, 0, 1);

        // pause after 2 RUN cycles, hold 10, resume: tick 2 cycles later reads 0:29
        step(0, 2'd1, 0, 0);
        step(0, 2'd1, 1, 0);
        step(0, 2'd1, 0, 0);
        step(0, 2'd1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 2'd1, 0, 0);
        check("paused_sec", int'(seconds), 30);
        step(0, 2'd1, 1, 0);
        step(0, 2'd1, 0, 0);
        check("resume_pre_tick", int'(seconds), 30);
        step(0, 2'd1, 0, 0);
        check("resume_tick_sec", int'(seconds), 29);

        // run on to 0:17, then start+clear together
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(0, 2'd1, 0, 0);
            if (seconds == 6'd17) seen = 1;
        end
        check("reach_0_17", int'(seen), 1);
        step(0, 2'd1, 1, 1);
        check("clr_win_running", int'(running), 0);
        check("clr_win_sec", int'(seconds), 30);

        // mode change during RUN is ignored; clear then shows 2:00
        step(0, 2'd0, 0, 0);
        step(0, 2'd0, 1, 0);
        for (int i = 0; i < CLK; i++) step(0, 2'd3, 0, 0);
        check("mode_ign_sec", int'(seconds), 4);
        check("mode_ign_min", int'(minutes), 0);
        step(0, 2'd3, 0, 1);
        check("clr_2m_min", int'(minutes), 2);
        check("clr_2m_sec", int'(seconds), 0);

        // reset mid-count discards progress
        step(0, 2'd3, 1, 0);
        for (int i = 0; i < 3 * CLK; i++) step(0, 2'd3, 0, 0);
        step(1, 2'd3, 0, 0);
        check("midrst_sec", int'(seconds), 5);
        check("midrst_run", int'(running), 0);

        // random pulses against the model
        md = 2'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) md = 2'($urandom_range(0, 3));
            step($urandom_range(0, 999) == 0, md,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
